// File: rtl/evu_pkg.sv
// Shared types and constants for the event-unit counter block.
package evu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TRIPPED = 2'd2
  } evu_cnt_state_e;

  localparam logic [1:0] PRIV_ENC_M = 2'b01;
  localparam logic [1:0] PRIV_ENC_S = 2'b10;
  localparam logic [1:0] PRIV_ENC_U = 2'b11;

  // Privilege 00 is not a real mode and never matches.
  function automatic logic priv_allowed(logic [1:0] priv, logic [2:0] mask);
    case (priv)
      PRIV_ENC_M: return mask[0];
      PRIV_ENC_S: return mask[1];
      PRIV_ENC_U: return mask[2];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/evu_event_counter_if.sv
// Event stream and counter read port between the event unit and the counter block.
interface evu_event_counter_if #(
  parameter int NUM_EVENTS = 4,
  parameter int ASID_WIDTH = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int IDX_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
);
  logic [NUM_EVENTS-1:0]   e_id;
  logic [ASID_WIDTH+1:0]   e_info;
  logic                    s_id;
  logic                    rd_req;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_valid;
  logic [CNT_WIDTH-1:0]    rd_data;

  modport master (
    output e_id, e_info, s_id, rd_req, rd_idx,
    input  rd_valid, rd_data
  );

  modport slave (
    input  e_id, e_info, s_id, rd_req, rd_idx,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/evu_event_filter.sv
// Qualifies event bits by privilege, ASID and stream id; one register stage.
module evu_event_filter
  import evu_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int ASID_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] e_id,
  input  logic [ASID_WIDTH+1:0] e_info,
  input  logic                  s_id,
  input  logic [2:0]            cfg_priv_mask,
  input  logic                  cfg_asid_en,
  input  logic [ASID_WIDTH-1:0] cfg_asid,
  input  logic                  cfg_sid,
  output logic [NUM_EVENTS-1:0] qual_p1
);

  typedef struct packed {
    logic [1:0]            priv;
    logic [ASID_WIDTH-1:0] asid;
  } e_info_t;

  e_info_t info;
  logic    match;

  assign info = e_info_t'(e_info);

  always_comb begin
    match = priv_allowed(info.priv, cfg_priv_mask)
            && (!cfg_asid_en || (info.asid == cfg_asid))
            && (s_id == cfg_sid);
  end

  // p0 -> p1: captures every cycle; clear drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      qual_p1 <= '0;
    end else begin
      qual_p1 <= e_id & {NUM_EVENTS{match}};
    end
  end

endmodule

// File: rtl/evu_event_counter.sv
// Per-line event counters with run/stop/trip control, sticky wrap flags and a
// one-cycle read port returning the pre-update counter value.
module evu_event_counter
  import evu_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int ASID_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  evu_event_counter_if.slave    evu,
  input  logic [2:0]            cfg_priv_mask_i,
  input  logic                  cfg_asid_en_i,
  input  logic [ASID_WIDTH-1:0] cfg_asid_i,
  input  logic                  cfg_sid_i,
  input  logic [CNT_WIDTH-1:0]  cfg_threshold_i,
  input  logic                  cmd_start_i,
  input  logic                  cmd_stop_i,
  input  logic                  cmd_clear_i,
  output logic [NUM_EVENTS-1:0] overflow_o,
  output logic                  irq_o,
  output logic [1:0]            state_o
);

  localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  evu_cnt_state_e        state_q, state_d;
  logic [NUM_EVENTS-1:0] qual_p1;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic                  trip;
  logic [CNT_WIDTH-1:0]  rd_sel;

  evu_event_filter #(
    .NUM_EVENTS (NUM_EVENTS),
    .ASID_WIDTH (ASID_WIDTH)
  ) u_filter (
    .clk           (clk_i),
    .rst           (rst_i),
    .clear         (cmd_clear_i),
    .e_id          (evu.e_id),
    .e_info        (evu.e_info),
    .s_id          (evu.s_id),
    .cfg_priv_mask (cfg_priv_mask_i),
    .cfg_asid_en   (cfg_asid_en_i),
    .cfg_asid      (cfg_asid_i),
    .cfg_sid       (cfg_sid_i),
    .qual_p1       (qual_p1)
  );

  // Trip looks at every counter's next value, so a wrap to zero never trips.
  always_comb begin : count_next
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    trip  = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if ((state_q == ST_RUN) && qual_p1[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        if (cnt_q[i] == '1) ovf_d[i] = 1'b1;
      end
      if ((cfg_threshold_i != '0) && (cnt_d[i] >= cfg_threshold_i)) trip = 1'b1;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    irq_o   = (state_q == ST_TRIPPED);
    state_o = state_q;
    case (state_q)
      ST_RUN: begin
        if (cmd_stop_i)  state_d = ST_IDLE;
        else if (trip)   state_d = ST_TRIPPED;
      end
      ST_TRIPPED: state_d = ST_TRIPPED;
      default: state_d = cmd_start_i ? ST_RUN : ST_IDLE;
    endcase
    if (cmd_clear_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin : fsm_reg
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // p1 -> p2: counters and sticky overflow flags.
  always_ff @(posedge clk_i) begin : count_reg
    if (rst_i || cmd_clear_i) begin
      for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;

  // Out-of-range indices fall through to zero.
  always_comb begin : rd_select
    rd_sel = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (evu.rd_idx == IDX_W'(i)) rd_sel = cnt_q[i];
    end
  end

  always_ff @(posedge clk_i) begin : rd_reg
    if (rst_i) begin
      evu.rd_valid <= 1'b0;
      evu.rd_data  <= '0;
    end else begin
      evu.rd_valid <= evu.rd_req;
      if (evu.rd_req) evu.rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_evu_event_counter.sv
// Scenario tasks plus randomized traffic checked against a cycle model of the counter block.
module tb_evu_event_counter;
  import evu_pkg::*;

  localparam int NE   = 4;
  localparam int AW   = 16;
  localparam int CW   = 8;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]    cfg_priv_mask;
  logic          cfg_asid_en;
  logic [AW-1:0] cfg_asid;
  logic          cfg_sid;
  logic [CW-1:0] cfg_threshold;
  logic          cmd_start, cmd_stop, cmd_clear;
  logic [NE-1:0] overflow;
  logic          irq;
  logic [1:0]    state;
  logic [2:0]    overflow3;
  logic          irq3;
  logic [1:0]    state3;

  evu_event_counter_if #(.NUM_EVENTS(NE), .ASID_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  evu_event_counter_if #(.NUM_EVENTS(3),  .ASID_WIDTH(AW), .CNT_WIDTH(CW)) bus3 ();

  evu_event_counter #(.NUM_EVENTS(NE), .ASID_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .evu(bus.slave),
    .cfg_priv_mask_i(cfg_priv_mask), .cfg_asid_en_i(cfg_asid_en), .cfg_asid_i(cfg_asid),
    .cfg_sid_i(cfg_sid), .cfg_threshold_i(cfg_threshold),
    .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop), .cmd_clear_i(cmd_clear),
    .overflow_o(overflow), .irq_o(irq), .state_o(state)
  );

  evu_event_counter #(.NUM_EVENTS(3), .ASID_WIDTH(AW), .CNT_WIDTH(CW)) dut3 (
    .clk_i(clk), .rst_i(rst), .evu(bus3.slave),
    .cfg_priv_mask_i(cfg_priv_mask), .cfg_asid_en_i(cfg_asid_en), .cfg_asid_i(cfg_asid),
    .cfg_sid_i(cfg_sid), .cfg_threshold_i(cfg_threshold),
    .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop), .cmd_clear_i(cmd_clear),
    .overflow_o(overflow3), .irq_o(irq3), .state_o(state3)
  );

  // Reference model of the main instance: 0=IDLE 1=RUN 2=TRIPPED.
  int          m_state;
  int          m_cnt [NE];
  logic [NE-1:0] m_ovf, m_qual;
  logic        m_rdv;
  int          m_rdd;
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic logic model_match();
    int p;
    p = int'(bus.e_info[AW+1:AW]);
    if (p == 0) return 1'b0;
    if (!cfg_priv_mask[p-1]) return 1'b0;
    if (cfg_asid_en && (bus.e_info[AW-1:0] != cfg_asid)) return 1'b0;
    return (bus.s_id == cfg_sid);
  endfunction

  task automatic tick();
    logic hit;
    if (rst) begin
      m_state = 0;
      for (int i = 0; i < NE; i++) m_cnt[i] = 0;
      m_ovf = '0; m_qual = '0; m_rdv = 1'b0; m_rdd = 0;
    end else begin
      m_rdv = bus.rd_req;
      if (bus.rd_req) m_rdd = m_cnt[bus.rd_idx];
      if (cmd_clear) begin
        m_state = 0;
        for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        m_ovf = '0; m_qual = '0;
      end else begin
        if (m_state == 1) begin
          hit = 1'b0;
          for (int i = 0; i < NE; i++) begin
            if (m_qual[i]) begin
              if (m_cnt[i] == MAXV) begin m_cnt[i] = 0; m_ovf[i] = 1'b1; end
              else m_cnt[i] = m_cnt[i] + 1;
            end
            if ((cfg_threshold != 0) && (m_cnt[i] >= int'(cfg_threshold))) hit = 1'b1;
          end
          if (cmd_stop) m_state = 0;
          else if (hit) m_state = 2;
        end else if ((m_state == 0) && cmd_start) begin
          m_state = 1;
        end
        m_qual = model_match() ? bus.e_id : '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_pass_filter();
    cfg_priv_mask = 3'b001; cfg_asid_en = 1'b0; cfg_asid = 16'h1234; cfg_sid = 1'b0;
    cfg_threshold = '0;
    bus.e_info  = {2'b01, 16'h1234}; bus.s_id  = 1'b0;
    bus3.e_info = {2'b01, 16'h1234}; bus3.s_id = 1'b0;
  endtask

  task automatic do_clear();
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
  endtask

  task automatic do_start();
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (overflow !== 4'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0000", overflow); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rdd: got %0d want 0", bus.rd_data); end
  endtask

  task automatic test_count();
    int exp_c [NE] = '{10, 0, 10, 0};
    set_pass_filter(); do_clear(); do_start();
    bus.e_id = 4'b0101;
    repeat (10) tick();
    bus.e_id = '0; tick();
    for (int i = 0; i < NE; i++) begin
      bus.rd_req = 1'b1; bus.rd_idx = 2'(i); tick();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== CW'(exp_c[i])) begin
        n_fail++; $display("FAIL count_rd%0d: valid=%b data=%0d want valid=1 data=%0d", i, bus.rd_valid, bus.rd_data, exp_c[i]);
      end
    end
    bus.rd_req = 1'b0; tick();
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL count_rdv_drop: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_filter();
    set_pass_filter(); do_clear(); do_start();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin bus.e_info = {2'b11, 16'h1234}; cfg_priv_mask = 3'b011; end
        1: begin cfg_asid_en = 1'b1; bus.e_info = {2'b01, 16'h1235}; end
        default: begin cfg_sid = 1'b1; bus.s_id = 1'b0; end
      endcase
      bus.e_id = 4'hF; repeat (4) tick();
      bus.e_id = '0; tick(); tick();
      for (int i = 0; i < NE; i++) begin
        bus.rd_req = 1'b1; bus.rd_idx = 2'(i); tick();
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'd0) begin
          n_fail++; $display("FAIL filter%0d_rd%0d: valid=%b data=%0d want valid=1 data=0", c, i, bus.rd_valid, bus.rd_data);
        end
      end
      bus.rd_req = 1'b0;
      set_pass_filter();
    end
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL filter_state: got %0d want 1", state); end
  endtask

  task automatic test_threshold();
    set_pass_filter(); do_clear();
    cfg_threshold = 8'd5; do_start();
    bus.e_id = 4'b0010; repeat (8) tick();
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL trip_state: got %0d want 2", state); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL trip_irq: got %b want 1", irq); end
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    repeat (3) tick();
    bus.e_id = '0; tick();
    bus.rd_req = 1'b1; bus.rd_idx = 2'd1; tick(); bus.rd_req = 1'b0;
    n_cmp++; if (bus.rd_data !== 8'd5) begin n_fail++; $display("FAIL trip_frozen: got %0d want 5", bus.rd_data); end
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL trip_hold: got %0d want 2", state); end
    do_clear();
    n_cmp++; if (state !== 2'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL trip_clear: state=%0d irq=%b want 0/0", state, irq); end
    bus.rd_req = 1'b1; bus.rd_idx = 2'd1; tick(); bus.rd_req = 1'b0;
    n_cmp++; if (bus.rd_data !== 8'd0) begin n_fail++; $display("FAIL trip_clear_cnt: got %0d want 0", bus.rd_data); end
    cfg_threshold = '0;
  endtask

  task automatic test_stop_vs_trip();
    set_pass_filter(); do_clear();
    cfg_threshold = 8'd3; do_start();
    bus.e_id = 4'b0001; tick(); tick(); tick();
    bus.e_id = '0; cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    n_cmp++; if (state !== 2'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL stop_trip_state: state=%0d irq=%b want 0/0", state, irq); end
    bus.rd_req = 1'b1; bus.rd_idx = 2'd0; tick(); bus.rd_req = 1'b0;
    n_cmp++; if (bus.rd_data !== 8'd3) begin n_fail++; $display("FAIL stop_trip_cnt: got %0d want 3", bus.rd_data); end
    cfg_threshold = '0;
  endtask

  task automatic test_wrap();
    set_pass_filter(); do_clear(); do_start();
    bus.e_id = 4'b1000; repeat (MAXV) tick();
    bus.e_id = '0; tick();
    bus.rd_req = 1'b1; bus.rd_idx = 2'd3; tick(); bus.rd_req = 1'b0;
    n_cmp++; if (bus.rd_data !== 8'd255) begin n_fail++; $display("FAIL wrap_pre: got %0d want 255", bus.rd_data); end
    n_cmp++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL wrap_pre_ovf: got %b want 0000", overflow); end
    bus.e_id = 4'b1000; tick(); bus.e_id = '0; tick();
    n_cmp++; if (overflow !== 4'b1000) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1000", overflow); end
    bus.rd_req = 1'b1; bus.rd_idx = 2'd3; tick(); bus.rd_req = 1'b0;
    n_cmp++; if (bus.rd_data !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 0", bus.rd_data); end
    repeat (3) tick();
    n_cmp++; if (overflow !== 4'b1000 || state !== 2'd1) begin n_fail++; $display("FAIL wrap_sticky: ovf=%b state=%0d want 1000/1", overflow, state); end
  endtask

  task automatic test_clear_start();
    set_pass_filter(); do_clear(); do_start();
    bus.e_id = 4'hF; repeat (3) tick();
    cmd_clear = 1'b1; cmd_start = 1'b1; tick(); cmd_clear = 1'b0; cmd_start = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL clr_start_state: got %0d want 0", state); end
    bus.e_id = '0; tick(); tick();
    for (int i = 0; i < NE; i++) begin
      bus.rd_req = 1'b1; bus.rd_idx = 2'(i); tick();
      n_cmp++;
      if (bus.rd_data !== 8'd0) begin n_fail++; $display("FAIL clr_start_rd%0d: got %0d want 0", i, bus.rd_data); end
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_pass_filter(); do_clear(); do_start();
    bus.e_id = 4'hF; repeat (3) tick();
    for (int i = 0; i < NE; i++) begin
      bus.rd_req = 1'b1; bus.rd_idx = 2'(i); tick();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== CW'(2 + i)) begin
        n_fail++; $display("FAIL b2b_rd%0d: valid=%b data=%0d want valid=1 data=%0d", i, bus.rd_valid, bus.rd_data, 2 + i);
      end
    end
    bus.rd_req = 1'b0; bus.e_id = '0; tick();
  endtask

  task automatic test_out_of_range();
    rst = 1'b1; tick(); rst = 1'b0;
    set_pass_filter(); do_start();
    bus3.e_id = 3'b111; repeat (3) tick();
    bus3.e_id = '0; tick();
    bus3.rd_req = 1'b1; bus3.rd_idx = 2'd3; tick();
    n_cmp++;
    if (bus3.rd_valid !== 1'b1 || bus3.rd_data !== 8'd0) begin
      n_fail++; $display("FAIL oob_rd: valid=%b data=%0d want valid=1 data=0", bus3.rd_valid, bus3.rd_data);
    end
    bus3.rd_idx = 2'd2; tick(); bus3.rd_req = 1'b0;
    n_cmp++; if (bus3.rd_data !== 8'd3) begin n_fail++; $display("FAIL oob_inrange: got %0d want 3", bus3.rd_data); end
  endtask

  task automatic test_reset_mid();
    set_pass_filter(); do_clear(); do_start();
    bus.e_id = 4'hF; repeat (4) tick();
    bus.rd_req = 1'b1; bus.rd_idx = 2'd0; rst = 1'b1; tick(); rst = 1'b0; bus.rd_req = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'd0 || state !== 2'd0 || overflow !== 4'b0) begin
      n_fail++; $display("FAIL reset_mid: rdv=%b rdd=%0d state=%0d ovf=%b want 0/0/0/0000", bus.rd_valid, bus.rd_data, state, overflow);
    end
    bus.e_id = '0;
  endtask

  task automatic test_random();
    set_pass_filter(); do_clear();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 60 == 0) begin
        cfg_priv_mask = 3'($urandom_range(0, 7));
        cfg_asid_en   = 1'($urandom_range(0, 1));
        cfg_asid      = 16'($urandom);
        cfg_sid       = 1'($urandom_range(0, 1));
        cfg_threshold = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(5, 60));
      end
      bus.e_id   = 4'($urandom);
      bus.e_info = {2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0) ? cfg_asid : 16'($urandom)};
      bus.s_id   = ($urandom_range(0, 3) != 0) ? cfg_sid : ~cfg_sid;
      cmd_start  = ($urandom_range(0, 99) < 10);
      cmd_stop   = ($urandom_range(0, 99) < 3);
      cmd_clear  = ($urandom_range(0, 99) < 2);
      rst        = ($urandom_range(0, 199) == 0);
      bus.rd_req = 1'($urandom_range(0, 1));
      bus.rd_idx = 2'($urandom_range(0, 3));
      tick();
      n_cmp++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state c%0d: got %0d want %0d", cyc, state, m_state); end
      n_cmp++; if (irq !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_irq c%0d: got %b want %b", cyc, irq, m_state == 2); end
      n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b want %b", cyc, overflow, m_ovf); end
      n_cmp++; if (bus.rd_valid !== m_rdv) begin n_fail++; $display("FAIL rnd_rdv c%0d: got %b want %b", cyc, bus.rd_valid, m_rdv); end
      n_cmp++; if (bus.rd_data !== CW'(m_rdd)) begin n_fail++; $display("FAIL rnd_rdd c%0d: got %0d want %0d", cyc, bus.rd_data, m_rdd); end
    end
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0; rst = 1'b0;
    bus.rd_req = 1'b0; bus.e_id = '0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_priv_mask = '0; cfg_asid_en = 1'b0; cfg_asid = '0; cfg_sid = 1'b0; cfg_threshold = '0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
    bus.e_id = '0;  bus.e_info = '0;  bus.s_id = 1'b0;  bus.rd_req = 1'b0;  bus.rd_idx = '0;
    bus3.e_id = '0; bus3.e_info = '0; bus3.s_id = 1'b0; bus3.rd_req = 1'b0; bus3.rd_idx = '0;
    #1;
    test_reset();
    test_count();
    test_filter();
    test_threshold();
    test_stop_vs_trip();
    test_wrap();
    test_clear_start();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
